// File: rtl/dsp_tapline_if.sv
// Bundled sample/readout signals of dsp_tapline.
// The producer/consumer side takes the master modport. The tap line takes the slave modport.
interface dsp_tapline_if #(
    parameter int WIDTH = 24,
    parameter int AW    = 3
);
    logic                 en;
    logic                 we;
    logic [WIDTH-1:0]     din;
    logic [AW-1:0]        tap;
    logic                 start;
    logic [WIDTH-1:0]     dout;
    logic                 dout_valid;
    logic                 busy;
    logic                 done;
    logic                 wr_drop;
    logic [AW:0]          fill;
    logic [WIDTH+AW:0]    sum;

    modport master (
        output en, we, din, tap, start,
        input  dout, dout_valid, busy, done, wr_drop, fill, sum
    );

    modport slave (
        input  en, we, din, tap, start,
        output dout, dout_valid, busy, done, wr_drop, fill, sum
    );
endinterface

// File: rtl/dsp_tapline.sv
// Parameterised word delay line with a direct read tap, fill tracking and a start-triggered sweep.
// Define DSP_TAPLINE_SUM_EN to accumulate the valid words of each sweep on the sum output.
module dsp_tapline #(
    parameter int               WIDTH   = 24,
    parameter int               DEPTH   = 8,
    parameter int               AW      = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic          clk,
    input logic          rst,
    dsp_tapline_if.slave bus
);

    localparam int              SW       = WIDTH + AW + 1;
    localparam logic [AW:0]     DEPTH_F  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] sr_q [DEPTH];
    logic [WIDTH-1:0] sr_d [DEPTH];
    logic [AW:0]      fill_q, fill_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             done_q, done_d;
    logic             wr_drop_q, wr_drop_d;

    logic [AW-1:0]    rd_sel;
    logic [WIDTH-1:0] rd_word;
    logic             rd_hit;
    logic             rd_valid;

    function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
        return (v == DEPTH_F) ? v : v + (AW+1)'(1);
    endfunction

    // Read mux: indices outside the line yield zero and never qualify as valid.
    always_comb begin
        rd_sel  = (state_q == S_SWEEP) ? idx_q : bus.tap;
        rd_word = '0;
        rd_hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_sel == AW'(i)) begin
                rd_word = sr_q[i];
                rd_hit  = 1'b1;
            end
        end
        rd_valid = rd_hit && ({1'b0, rd_sel} < fill_q);
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sr_d         = sr_q;
        fill_d       = fill_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        done_d       = 1'b0;
        wr_drop_d    = 1'b0;

        if (bus.en) begin
            if (bus.we) begin
                if (state_q == S_SWEEP) begin
                    wr_drop_d = 1'b1;
                end else begin
                    sr_d[0] = bus.din;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr_d[i] = sr_q[i-1];
                    end
                    fill_d = sat_inc(fill_q);
                end
            end

            dout_d       = rd_word;
            dout_valid_d = rd_valid;

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_SWEEP;
                        idx_d   = '0;
                    end
                end
                S_SWEEP: begin
                    idx_d = idx_q + AW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            fill_q       <= '0;
            dout_q       <= RST_VAL;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            wr_drop_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= RST_VAL;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fill_q       <= fill_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            done_q       <= done_d;
            wr_drop_q    <= wr_drop_d;
            sr_q         <= sr_d;
        end
    end

`ifdef DSP_TAPLINE_SUM_EN
    logic [SW-1:0] sum_q, sum_d;

    // Cleared on the accepted start so the final total survives until the next sweep.
    always_comb begin
        sum_d = sum_q;
        if (bus.en) begin
            if (state_q == S_IDLE && bus.start) begin
                sum_d = '0;
            end else if (state_q == S_SWEEP && rd_valid) begin
                sum_d = sum_q + SW'(rd_word);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign bus.sum = sum_q;
`else
    assign bus.sum = '0;
`endif

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = (state_q == S_SWEEP);
    assign bus.done       = done_q;
    assign bus.wr_drop    = wr_drop_q;
    assign bus.fill       = fill_q;

endmodule
